aha_clk_en_ctrl: RTL and testbench
==================================

AHA_CLK_EN_CTRL -- requirements
Module: aha_clk_en_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 4, number of independently gated clock-enable domains.
REQ-002 Parameter CNT_W, default 8, width of the idle-hysteresis counter and threshold.
REQ-003 clk  input  1  free-running controller clock, same clock as every downstream clock-enable gate cell.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cfg_gate_en  input  NUM_DOM  per-domain permission to gate; 0 forces the domain to run.
REQ-006 cfg_idle_thresh  input  CNT_W  idle cycles required before a gate request; quasi-static.
REQ-007 dom_idle  input  NUM_DOM  per-domain idle indication from the domain logic.
REQ-008 dom_wake  input  NUM_DOM  per-domain wake request (interrupt/traffic pending).
REQ-009 qacceptn  input  NUM_DOM  per-domain Q-channel accept, active-low.
REQ-010 qdeny  input  NUM_DOM  per-domain Q-channel deny, active-high.
REQ-011 qreqn  output  NUM_DOM  per-domain Q-channel quiescence request, active-low.
REQ-012 clk_en  output  NUM_DOM  per-domain enable driven into the E input of the domain clock-enable gate cell.
REQ-013 gated  output  NUM_DOM  per-domain status, 1 while the domain is in STOP.

Function
REQ-014 Each domain runs an independent FSM with states RUN, COUNT, REQ, STOP, EXIT; all outputs registered.
REQ-015 RUN: clk_en=1, qreqn=1; go to COUNT with count cleared when cfg_gate_en & dom_idle & ~dom_wake.
REQ-016 COUNT: clk_en=1, qreqn=1; if ~cfg_gate_en | ~dom_idle | dom_wake go to RUN; else if count==cfg_idle_thresh go to REQ; else increment count.
REQ-017 Threshold 0 reaches REQ one cycle after entering COUNT; count never wraps (it stops at cfg_idle_thresh).
REQ-018 REQ: qreqn=0, clk_en=1; qdeny=1 goes to EXIT; else qacceptn=0 goes to STOP; else hold.
REQ-019 Simultaneous qdeny=1 and qacceptn=0 in REQ: deny wins, go to EXIT.
REQ-020 STOP: qreqn=0, clk_en=0, gated=1; dom_wake | ~cfg_gate_en | ~dom_idle goes to EXIT.
REQ-021 EXIT: qreqn=1, clk_en=1; go to RUN when qacceptn=1 and qdeny=0; otherwise hold.
REQ-022 Latency: clk_en falls the cycle after qacceptn=0 is sampled in REQ; clk_en rises the cycle after the wake condition is sampled in STOP.
REQ-023 Wake or cfg_gate_en deassertion during REQ does not abort the handshake; it is honoured in STOP (Q-channel request is never withdrawn before accept/deny).
REQ-024 Domains do not interact; events on different domains in the same cycle are all processed that cycle.

Reset
REQ-025 On reset_n low every FSM enters RUN asynchronously: clk_en all 1, qreqn all 1, gated all 0, counts 0.
REQ-026 Reset mid-handshake (REQ/STOP/EXIT) returns to RUN with clocks enabled; no handshake completion is awaited.
REQ-027 reset_n is deasserted synchronously to clk by the instantiating level's reset synchronizer.

Structure
REQ-028 Shared package holds the FSM state enum (RUN, COUNT, REQ, STOP, EXIT) and default NUM_DOM/CNT_W constants.
REQ-029 One sub-module aha_clk_en_dom_fsm implements a single domain; the top instantiates NUM_DOM copies via generate.

Verification
REQ-030 thresh=3, domain 0 idle held, qacceptn answers 2 cycles after qreqn falls -> qreqn falls 5 cycles after idle seen (RUN, COUNT x4), clk_en falls 1 cycle after accept, gated=1.
REQ-031 Domain 0 in STOP, pulse dom_wake 1 cycle -> clk_en=1 and qreqn=1 next cycle; RUN entered 1 cycle after qacceptn returns high.
REQ-032 In REQ drive qdeny=1 and qacceptn=0 same cycle -> EXIT, clk_en never drops, RUN after qdeny clears.
REQ-033 thresh=3, dom_idle drops at count 2 -> RUN, qreqn never falls; thresh=0 -> REQ one cycle after COUNT.
REQ-034 Assert reset_n low while domain 2 in STOP -> clk_en[2]=1, qreqn[2]=1, gated[2]=0 immediately, without a clock edge.
REQ-035 All four domains idle with staggered accepts -> each gates independently; cfg_gate_en=0 on domain 1 keeps it in RUN.

Source files
------------

// File: rtl/aha_clk_en_ctrl_pkg.sv
// Shared types and defaults for the per-domain clock-enable controller.
package aha_clk_en_ctrl_pkg;

  localparam int DEF_NUM_DOM = 4;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_COUNT = 3'd1,
    ST_REQ   = 3'd2,
    ST_STOP  = 3'd3,
    ST_EXIT  = 3'd4
  } dom_state_e;

  // A domain may be stopped only while permitted, idle and not asked to wake.
  function automatic logic may_gate(input logic gate_en, input logic idle, input logic wake);
    return gate_en & idle & ~wake;
  endfunction

endpackage

// File: rtl/aha_clk_en_ctrl_dom_fsm.sv
// Single-domain idle-hysteresis and Q-channel clock-gating FSM with registered outputs.
module aha_clk_en_dom_fsm
  import aha_clk_en_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gate_en,
  input  logic [CNT_W-1:0] idle_thresh,
  input  logic             idle,
  input  logic             wake,
  input  logic             qacceptn,
  input  logic             qdeny,
  output logic             qreqn,
  output logic             clk_en,
  output logic             gated
);

  dom_state_e       state;
  logic [CNT_W-1:0] count;

  // State, hysteresis counter and outputs all update together so outputs are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_RUN;
      count  <= '0;
      qreqn  <= 1'b1;
      clk_en <= 1'b1;
      gated  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (may_gate(gate_en, idle, wake)) begin
            state <= ST_COUNT;
            count <= '0;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_COUNT: begin
          if (!may_gate(gate_en, idle, wake)) begin
            state <= ST_RUN;
          end else if (count >= idle_thresh) begin
            // >= rather than == keeps the counter from wrapping if the threshold is lowered.
            state <= ST_REQ;
            qreqn <= 1'b0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        ST_REQ: begin
          // Wake is deliberately ignored here: the request is never withdrawn before a response.
          if (qdeny) begin
            state <= ST_EXIT;
            qreqn <= 1'b1;
          end else if (!qacceptn) begin
            state  <= ST_STOP;
            clk_en <= 1'b0;
            gated  <= 1'b1;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_STOP: begin
          if (!may_gate(gate_en, idle, wake)) begin
            state  <= ST_EXIT;
            qreqn  <= 1'b1;
            clk_en <= 1'b1;
            gated  <= 1'b0;
          end else begin
            state <= ST_STOP;
          end
        end
        ST_EXIT: begin
          if (qacceptn && !qdeny) begin
            state <= ST_RUN;
          end else begin
            state <= ST_EXIT;
          end
        end
        default: begin
          state  <= ST_RUN;
          count  <= '0;
          qreqn  <= 1'b1;
          clk_en <= 1'b1;
          gated  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/aha_clk_en_ctrl.sv
// Clock-enable controller: NUM_DOM independent Q-channel gating domains.
module aha_clk_en_ctrl
  import aha_clk_en_ctrl_pkg::*;
#(
  parameter int NUM_DOM = DEF_NUM_DOM,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_DOM-1:0] cfg_gate_en,
  input  logic [CNT_W-1:0]   cfg_idle_thresh,
  input  logic [NUM_DOM-1:0] dom_idle,
  input  logic [NUM_DOM-1:0] dom_wake,
  input  logic [NUM_DOM-1:0] qacceptn,
  input  logic [NUM_DOM-1:0] qdeny,
  output logic [NUM_DOM-1:0] qreqn,
  output logic [NUM_DOM-1:0] clk_en,
  output logic [NUM_DOM-1:0] gated
);

  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    aha_clk_en_dom_fsm #(
      .CNT_W(CNT_W)
    ) u_dom (
      .clk         (clk),
      .reset_n     (reset_n),
      .gate_en     (cfg_gate_en[i]),
      .idle_thresh (cfg_idle_thresh),
      .idle        (dom_idle[i]),
      .wake        (dom_wake[i]),
      .qacceptn    (qacceptn[i]),
      .qdeny       (qdeny[i]),
      .qreqn       (qreqn[i]),
      .clk_en      (clk_en[i]),
      .gated       (gated[i])
    );
  end

endmodule

// File: tb/tb_aha_clk_en_ctrl.sv
// Directed and randomized bench for aha_clk_en_ctrl against a phase/streak reference model.
module tb_aha_clk_en_ctrl;

  localparam int ND = 4;
  localparam int CW = 8;
  localparam int P_ACT   = 0;
  localparam int P_REQ   = 1;
  localparam int P_STOP  = 2;
  localparam int P_LEAVE = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [ND-1:0] cfg_gate_en, dom_idle, dom_wake, qacceptn, qdeny;
  logic [CW-1:0] cfg_idle_thresh;
  logic [ND-1:0] qreqn, clk_en, gated;

  int checks   = 0;
  int failures = 0;
  int phase  [ND];
  int streak [ND];
  int age    [ND];

  aha_clk_en_ctrl #(.NUM_DOM(ND), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_gate_en     (cfg_gate_en),
    .cfg_idle_thresh (cfg_idle_thresh),
    .dom_idle        (dom_idle),
    .dom_wake        (dom_wake),
    .qacceptn        (qacceptn),
    .qdeny           (qdeny),
    .qreqn           (qreqn),
    .clk_en          (clk_en),
    .gated           (gated)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      phase[d] = P_ACT; streak[d] = 0; age[d] = 0;
    end
  endtask

  // A gate request is issued after thresh+2 consecutive qualifying samples.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      bit qual;
      qual = cfg_gate_en[d] && dom_idle[d] && !dom_wake[d];
      case (phase[d])
        P_ACT: begin
          if (qual) begin
            streak[d]++;
            if (streak[d] >= int'(cfg_idle_thresh) + 2) begin
              phase[d] = P_REQ; streak[d] = 0;
            end
          end else streak[d] = 0;
        end
        P_REQ:   if (qdeny[d]) phase[d] = P_LEAVE; else if (!qacceptn[d]) phase[d] = P_STOP;
        P_STOP:  if (!qual) phase[d] = P_LEAVE;
        P_LEAVE: if (qacceptn[d] && !qdeny[d]) begin phase[d] = P_ACT; streak[d] = 0; end
        default: phase[d] = P_ACT;
      endcase
    end
  endtask

  task automatic compare();
    logic [ND-1:0] e_en, e_rq, e_gt;
    for (int d = 0; d < ND; d++) begin
      e_en[d] = (phase[d] != P_STOP);
      e_rq[d] = (phase[d] == P_ACT) || (phase[d] == P_LEAVE);
      e_gt[d] = (phase[d] == P_STOP);
    end
    check("model_clk_en", 32'(clk_en), 32'(e_en));
    check("model_qreqn", 32'(qreqn), 32'(e_rq));
    check("model_gated", 32'(gated), 32'(e_gt));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Q-channel responder; mode 0 accepts domain d after d+1 request cycles, mode 1 is random.
  task automatic respond(input int mode);
    for (int d = 0; d < ND; d++) begin
      case (phase[d])
        P_REQ: begin
          age[d]++;
          if (mode == 0) begin
            qacceptn[d] = (age[d] > d) ? 1'b0 : 1'b1;
            qdeny[d] = 1'b0;
          end else begin
            int r;
            r = int'($urandom_range(0, 9));
            qdeny[d]    = (r == 0);
            qacceptn[d] = (r == 0) ? 1'($urandom_range(0, 1)) : ((r < 4) ? 1'b0 : 1'b1);
          end
        end
        P_STOP: begin
          qacceptn[d] = 1'b0; qdeny[d] = 1'b0;
        end
        P_LEAVE: begin
          if ((mode == 0) || ($urandom_range(0, 1) == 1)) qacceptn[d] = 1'b1;
          if ((mode == 0) || ($urandom_range(0, 1) == 1)) qdeny[d] = 1'b0;
        end
        default: begin
          qacceptn[d] = 1'b1; qdeny[d] = 1'b0; age[d] = 0;
        end
      endcase
    end
  endtask

  task automatic quiet_inputs();
    cfg_gate_en = 4'hF; dom_idle = 4'h0; dom_wake = 4'h0; qacceptn = 4'hF; qdeny = 4'h0;
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_idle_thresh = 8'd3;
    quiet_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_clk_en", 32'(clk_en), 32'hF);
    check("reset_qreqn", 32'(qreqn), 32'hF);
    check("reset_gated", 32'(gated), 32'h0);
    reset_n = 1'b1;

    // Idle hysteresis with thresh=3, then accept two cycles after the request.
    dom_idle[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("thr3_qreqn_still_high", 32'(qreqn[0]), 32'h1);
    end
    step();
    check("thr3_qreqn_falls", 32'(qreqn[0]), 32'h0);
    check("thr3_clk_en_in_req", 32'(clk_en[0]), 32'h1);
    step();
    step();
    qacceptn[0] = 1'b0;
    step();
    check("accept_clk_en_falls", 32'(clk_en[0]), 32'h0);
    check("accept_gated", 32'(gated[0]), 32'h1);

    // One-cycle wake pulse out of STOP.
    dom_wake[0] = 1'b1;
    step();
    check("wake_clk_en", 32'(clk_en[0]), 32'h1);
    check("wake_qreqn", 32'(qreqn[0]), 32'h1);
    check("wake_gated", 32'(gated[0]), 32'h0);
    dom_wake[0] = 1'b0;
    step();
    check("exit_hold_qreqn", 32'(qreqn[0]), 32'h1);
    qacceptn[0] = 1'b1;
    dom_idle[0] = 1'b0;
    step();
    step();

    // Deny and accept together: deny wins and the clock never stops.
    dom_idle[0] = 1'b1;
    repeat (5) step();
    check("deny_setup_qreqn", 32'(qreqn[0]), 32'h0);
    qdeny[0] = 1'b1;
    qacceptn[0] = 1'b0;
    step();
    check("deny_qreqn", 32'(qreqn[0]), 32'h1);
    check("deny_clk_en", 32'(clk_en[0]), 32'h1);
    step();
    check("deny_hold_clk_en", 32'(clk_en[0]), 32'h1);
    qdeny[0] = 1'b0;
    qacceptn[0] = 1'b1;
    dom_idle[0] = 1'b0;
    step();
    check("deny_done_clk_en", 32'(clk_en[0]), 32'h1);

    // Idle drops at count 2: no request is ever issued.
    dom_idle[0] = 1'b1;
    repeat (3) step();
    dom_idle[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_qreqn_high", 32'(qreqn[0]), 32'h1);
    end

    // Threshold 0: request one cycle after entering COUNT.
    cfg_idle_thresh = 8'd0;
    dom_idle[0] = 1'b1;
    step();
    check("thr0_count_qreqn", 32'(qreqn[0]), 32'h1);
    step();
    check("thr0_req_qreqn", 32'(qreqn[0]), 32'h0);
    qdeny[0] = 1'b1;
    step();
    qdeny[0] = 1'b0;
    dom_idle[0] = 1'b0;
    step();

    // Asynchronous reset while domain 2 is stopped.
    dom_idle[2] = 1'b1;
    step();
    step();
    check("d2_req_qreqn", 32'(qreqn[2]), 32'h0);
    qacceptn[2] = 1'b0;
    step();
    check("d2_stop_gated", 32'(gated[2]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_clk_en2", 32'(clk_en[2]), 32'h1);
    check("async_rst_qreqn2", 32'(qreqn[2]), 32'h1);
    check("async_rst_gated2", 32'(gated[2]), 32'h0);
    model_reset();
    quiet_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    compare();

    // All domains idle, staggered accepts, domain 1 not permitted to gate.
    cfg_idle_thresh = 8'd1;
    cfg_gate_en = 4'b1101;
    dom_idle = 4'hF;
    repeat (14) begin
      step();
      respond(0);
    end
    check("multi_gated", 32'(gated), 32'hD);
    check("multi_clk_en", 32'(clk_en), 32'h2);
    dom_wake = 4'hF;
    step();
    respond(0);
    dom_wake = 4'h0;
    dom_idle = 4'h0;
    repeat (3) begin
      step();
      respond(0);
    end
    check("multi_all_running", 32'(clk_en), 32'hF);

    // Randomized traffic in several reset-separated chunks.
    for (int chunk = 0; chunk < 4; chunk++) begin
      #3;
      reset_n = 1'b0;
      model_reset();
      quiet_inputs();
      cfg_idle_thresh = 8'($urandom_range(0, 4));
      @(negedge clk);
      reset_n = 1'b1;
      compare();
      repeat (150) begin
        for (int d = 0; d < ND; d++) begin
          cfg_gate_en[d] = ($urandom_range(0, 15) != 0);
          if ($urandom_range(0, 7) == 0) dom_idle[d] = ~dom_idle[d];
          dom_wake[d] = ($urandom_range(0, 19) == 0);
        end
        respond(1);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
